// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-point majority vote per bit,
// false-start rejection, parity/framing/overrun flags, break hold-off, valid/ready output.
module uart_rx_param #(
    parameter int CLK_DIV    = 28,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic ODD = (PARITY == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic [2:0]           state;
    logic                 rxd_m, rxd_s, rxd_d;
    logic [TW-1:0]        tick_cnt;
    logic [SW-1:0]        samp_cnt;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] data;
    logic                 perr, ferr;
    logic                 deliver;

    logic tick, decide, vote, fall, par_exp;

    assign tick    = (tick_cnt == TW'(CLK_DIV - 1));
    assign decide  = tick && (samp_cnt == SW'(M + 1));
    // third sample is the live synchronised value at the decision tick
    assign vote    = (smp0 & smp1) | (smp0 & rxd_s) | (smp1 & rxd_s);
    assign fall    = rxd_d & ~rxd_s;
    assign par_exp = (^data) ^ ODD;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            rxd_d      <= 1'b1;
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            smp0       <= 1'b1;
            smp1       <= 1'b1;
            data       <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            deliver    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rxd_m   <= rxd;
            rxd_s   <= rxd_m;
            rxd_d   <= rxd_s;
            deliver <= 1'b0;
            overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    tick_cnt <= '0;
                    samp_cnt <= '0;
                    if (fall) begin
                        state <= S_START;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                    end
                end
                S_BREAK: begin
                    if (rxd_s)
                        state <= S_IDLE;
                end
                default: begin
                    if (tick) begin
                        tick_cnt <= '0;
                        samp_cnt <= (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
                        if (samp_cnt == SW'(M - 1))
                            smp0 <= rxd_s;
                        if (samp_cnt == SW'(M))
                            smp1 <= rxd_s;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end

                    if (decide) begin
                        case (state)
                            S_START: begin
                                bit_cnt <= '0;
                                state   <= vote ? S_IDLE : S_DATA;
                            end
                            S_DATA: begin
                                data    <= {vote, data[DATA_BITS-1:1]};
                                bit_cnt <= bit_cnt + 1'b1;
                                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                                    stop_cnt <= 1'b0;
                                    state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                                end
                            end
                            S_PARITY: begin
                                perr  <= (vote != par_exp);
                                state <= S_STOP;
                            end
                            default: begin
                                if (!vote)
                                    ferr <= 1'b1;
                                if (stop_cnt == 1'(STOP_BITS - 1)) begin
                                    deliver <= 1'b1;
                                    state   <= vote ? S_IDLE : S_BREAK;
                                end else begin
                                    stop_cnt <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            endcase

            // a fresh word takes priority over a same-cycle accept
            if (deliver) begin
                dout       <= data;
                parity_err <= perr;
                frame_err  <= ferr;
                dout_valid <= 1'b1;
                overrun    <= dout_valid & ~dout_ready;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance,
// 64 clk per bit (CLK_DIV=4, OVERSAMPLE=16).
module tb_uart_rx_param;

    localparam int BIT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_rxd = 1'b1, a_ready = 1'b1;
    logic       b_rxd = 1'b1, b_ready = 1'b1;
    logic [7:0] a_dout, b_dout;
    logic       a_valid, a_perr, a_ferr, a_ovr, a_busy;
    logic       b_valid, b_perr, b_ferr, b_ovr, b_busy;

    int tests = 0;
    int fails = 0;
    int a_rise = 0, b_rise = 0, a_ovr_cnt = 0;
    logic a_vprev = 1'b0, b_vprev = 1'b0;

    uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rxd(a_rxd), .dout(a_dout), .dout_valid(a_valid),
        .dout_ready(a_ready), .parity_err(a_perr), .frame_err(a_ferr),
        .overrun(a_ovr), .busy(a_busy)
    );

    uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .rxd(b_rxd), .dout(b_dout), .dout_valid(b_valid),
        .dout_ready(b_ready), .parity_err(b_perr), .frame_err(b_ferr),
        .overrun(b_ovr), .busy(b_busy)
    );

    // count new-word events and overrun pulses away from the active edge
    always @(negedge clk) begin
        a_vprev <= a_valid;
        b_vprev <= b_valid;
        if (a_valid && !a_vprev) a_rise <= a_rise + 1;
        if (b_valid && !b_vprev) b_rise <= b_rise + 1;
        if (a_ovr) a_ovr_cnt <= a_ovr_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rxd(input logic sel_b, input logic v);
        if (sel_b) b_rxd = v;
        else       a_rxd = v;
    endtask

    // bits[0] goes first; glitch_bit gets a 1-clk inversion aligned to its centre sample
    task automatic send_bits(input logic sel_b, input logic [11:0] bits, input int n, input int glitch_bit);
        for (int i = 0; i < n; i++) begin
            set_rxd(sel_b, bits[i]);
            if (i == glitch_bit) begin
                repeat (36) @(negedge clk);
                set_rxd(sel_b, ~bits[i]);
                @(negedge clk);
                set_rxd(sel_b, bits[i]);
                repeat (BIT - 37) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 16'(a_valid), 16'h0);
        check("rst_dout",  16'(a_dout),  16'h0);
        check("rst_perr",  16'(a_perr),  16'h0);
        check("rst_ferr",  16'(a_ferr),  16'h0);
        check("rst_ovr",   16'(a_ovr),   16'h0);
        check("rst_busy",  16'(a_busy),  16'h0);
        check("rst_b_valid", 16'(b_valid), 16'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 8N1 0xA5 with ready high
        send_bits(1'b0, 12'({1'b1, 8'hA5, 1'b0}), 10, -1);
        repeat (BIT) @(negedge clk);
        check("a5_words", 16'(a_rise), 16'd1);
        check("a5_dout",  16'(a_dout), 16'h00A5);
        check("a5_perr",  16'(a_perr), 16'h0);
        check("a5_ferr",  16'(a_ferr), 16'h0);
        check("a5_valid_accepted", 16'(a_valid), 16'h0);
        check("a5_busy_idle", 16'(a_busy), 16'h0);

        // 8E1 0x3C: wrong parity bit 1, then correct parity bit 0
        send_bits(1'b1, 12'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, -1);
        repeat (BIT) @(negedge clk);
        check("par1_words", 16'(b_rise), 16'd1);
        check("par1_dout",  16'(b_dout), 16'h003C);
        check("par1_perr",  16'(b_perr), 16'h1);
        check("par1_ferr",  16'(b_ferr), 16'h0);
        send_bits(1'b1, 12'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, -1);
        repeat (BIT) @(negedge clk);
        check("par0_words", 16'(b_rise), 16'd2);
        check("par0_dout",  16'(b_dout), 16'h003C);
        check("par0_perr",  16'(b_perr), 16'h0);

        // false start: 20 clk low
        a_rxd = 1'b0;
        repeat (20) @(negedge clk);
        check("fs_busy_high", 16'(a_busy), 16'h1);
        a_rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        check("fs_busy_low", 16'(a_busy), 16'h0);
        check("fs_no_word",  16'(a_rise), 16'd1);

        // 0x55 with a one-clock glitch on data bit 0
        send_bits(1'b0, 12'({1'b1, 8'h55, 1'b0}), 10, 1);
        repeat (BIT) @(negedge clk);
        check("gl_words", 16'(a_rise), 16'd2);
        check("gl_dout",  16'(a_dout), 16'h0055);

        // stop bit 0 followed by a long break
        send_bits(1'b0, 12'({1'b0, 8'hC3, 1'b0}), 10, -1);
        repeat (19 * BIT) @(negedge clk);
        check("brk_words", 16'(a_rise), 16'd3);
        check("brk_dout",  16'(a_dout), 16'h00C3);
        check("brk_ferr",  16'(a_ferr), 16'h1);
        check("brk_perr",  16'(a_perr), 16'h0);
        check("brk_busy",  16'(a_busy), 16'h1);
        a_rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        check("brk_busy_low",  16'(a_busy), 16'h0);
        check("brk_one_word",  16'(a_rise), 16'd3);

        // back-to-back 0x11, 0x22 with consumer stalled
        a_ready = 1'b0;
        send_bits(1'b0, 12'({1'b1, 8'h11, 1'b0}), 10, -1);
        send_bits(1'b0, 12'({1'b1, 8'h22, 1'b0}), 10, -1);
        repeat (BIT / 2) @(negedge clk);
        check("ovr_rises",   16'(a_rise),    16'd4);
        check("ovr_pulses",  16'(a_ovr_cnt), 16'd1);
        check("ovr_valid",   16'(a_valid),   16'h1);
        check("ovr_dout",    16'(a_dout),    16'h0022);
        check("ovr_ferr",    16'(a_ferr),    16'h0);

        // reset in the middle of the data bits of 0x77
        send_bits(1'b0, 12'({3'b111, 1'b0}), 4, -1);
        rst   = 1'b1;
        a_rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 16'(a_valid), 16'h0);
        check("mrst_dout",  16'(a_dout),  16'h0);
        check("mrst_busy",  16'(a_busy),  16'h0);
        check("mrst_ovr",   16'(a_ovr),   16'h0);
        repeat (BIT) @(negedge clk);
        a_ready = 1'b1;
        send_bits(1'b0, 12'({1'b1, 8'h5A, 1'b0}), 10, -1);
        repeat (BIT) @(negedge clk);
        check("5a_words", 16'(a_rise), 16'd5);
        check("5a_dout",  16'(a_dout), 16'h005A);
        check("5a_perr",  16'(a_perr), 16'h0);
        check("5a_ferr",  16'(a_ferr), 16'h0);
        check("5a_no_ovr", 16'(a_ovr_cnt), 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
